// File: rtl/riscv_div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller.
// State encoding and RV32M divide opcode masks.
package riscv_div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_KILL = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam logic [31:0] INST_DIV_MASK = 32'hFE00_707F;
  localparam logic [31:0] INST_DIV      = 32'h0200_4033;
  localparam logic [31:0] INST_DIVU     = 32'h0200_5033;
  localparam logic [31:0] INST_REM      = 32'h0200_6033;
  localparam logic [31:0] INST_REMU     = 32'h0200_7033;

  function automatic logic is_div_op(input logic [31:0] insn);
    logic [31:0] m;
    m = insn & INST_DIV_MASK;
    return (m == INST_DIV) || (m == INST_DIVU) ||
           (m == INST_REM) || (m == INST_REMU);
  endfunction

endpackage

// File: rtl/riscv_div_issue_ctrl.sv
// Divider issue controller: launches one divide op, tracks its rd,
// returns the result on a valid/ready writeback port, handles flush/hang.
module riscv_div_issue_ctrl
  import riscv_div_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 48,
  parameter int TIMER_W        = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_opcode,
  input  logic [31:0] issue_pc,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_ra,
  input  logic [4:0]  issue_rb,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic        flush,
  output logic        div_op_valid,
  output logic [31:0] div_op_code,
  output logic [31:0] div_op_pc,
  output logic        div_op_invalid,
  output logic [4:0]  div_op_rd,
  output logic [4:0]  div_op_ra,
  output logic [4:0]  div_op_rb,
  output logic [31:0] div_op_a,
  output logic [31:0] div_op_b,
  input  logic        div_res_valid,
  input  logic [31:0] div_res_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_value,
  output logic [31:0] wb_pc,
  input  logic [4:0]  chk_ra,
  input  logic [4:0]  chk_rb,
  output logic        hazard,
  output logic        busy,
  output logic        err_timeout
);

  localparam logic [TIMER_W-1:0] TMO = TIMER_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               err_q, err_d;
  logic               op_valid_q, op_valid_d;
  logic [31:0]        op_code_q, op_code_d;
  logic [31:0]        op_pc_q, op_pc_d;
  logic [4:0]         op_rd_q, op_rd_d;
  logic [4:0]         op_ra_q, op_ra_d;
  logic [4:0]         op_rb_q, op_rb_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_value_q, wb_value_d;
  logic [31:0]        wb_pc_q, wb_pc_d;
  logic               ready;
  logic               accept;
  logic               tmo_hit;
  logic               live;

  assign ready   = (state_q == S_IDLE) |
                   ((state_q == S_WB) & wb_ready & ~flush);
  assign accept  = issue_valid & ready & ~flush;
  assign tmo_hit = (timer_q == TMO);
  assign live    = (state_q == S_BUSY) | (state_q == S_WB);

  // Next-state, watchdog and capture logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    err_d      = err_q;
    op_valid_d = 1'b0;
    op_code_d  = op_code_q;
    op_pc_d    = op_pc_q;
    op_rd_d    = op_rd_q;
    op_ra_d    = op_ra_q;
    op_rb_d    = op_rb_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    wb_rd_d    = wb_rd_q;
    wb_value_d = wb_value_q;
    wb_pc_d    = wb_pc_q;
    unique case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        timer_d = timer_q + 1'b1;
        if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (flush) begin
          state_d = div_res_valid ? S_IDLE : S_KILL;
        end else if (div_res_valid) begin
          if (op_rd_q == 5'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_WB;
            wb_rd_d    = op_rd_q;
            wb_pc_d    = op_pc_q;
            wb_value_d = div_res_out;
          end
        end
      end
      S_KILL: begin
        timer_d = timer_q + 1'b1;
        if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (div_res_valid) begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (wb_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d    = S_BUSY;
      timer_d    = '0;
      op_valid_d = 1'b1;
      op_code_d  = issue_opcode;
      op_pc_d    = issue_pc;
      op_rd_d    = issue_rd;
      op_ra_d    = issue_ra;
      op_rb_d    = issue_rb;
      op_a_d     = issue_a;
      op_b_d     = issue_b;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      err_q      <= 1'b0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      op_pc_q    <= '0;
      op_rd_q    <= '0;
      op_ra_q    <= '0;
      op_rb_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wb_rd_q    <= '0;
      wb_value_q <= '0;
      wb_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      op_pc_q    <= op_pc_d;
      op_rd_q    <= op_rd_d;
      op_ra_q    <= op_ra_d;
      op_rb_q    <= op_rb_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wb_rd_q    <= wb_rd_d;
      wb_value_q <= wb_value_d;
      wb_pc_q    <= wb_pc_d;
    end
  end

  assign issue_ready    = ready;
  assign div_op_valid   = op_valid_q;
  assign div_op_code    = op_code_q;
  assign div_op_pc      = op_pc_q;
  assign div_op_invalid = 1'b0;
  assign div_op_rd      = op_rd_q;
  assign div_op_ra      = op_ra_q;
  assign div_op_rb      = op_rb_q;
  assign div_op_a       = op_a_q;
  assign div_op_b       = op_b_q;
  assign wb_valid       = (state_q == S_WB);
  assign wb_rd          = wb_rd_q;
  assign wb_value       = wb_value_q;
  assign wb_pc          = wb_pc_q;
  assign busy           = (state_q != S_IDLE);
  assign err_timeout    = err_q;
  assign hazard         = live & (op_rd_q != 5'd0) &
                          ((op_rd_q == chk_ra) | (op_rd_q == chk_rb));

endmodule

// File: tb/tb_riscv_div_issue_ctrl.sv
// Bench for riscv_div_issue_ctrl with a behavioural iterative divider.
// Writeback results are checked against a queue of expected entries.
module tb_riscv_div_issue_ctrl;
  import riscv_div_issue_ctrl_pkg::*;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] issue_opcode = '0;
  logic [31:0] issue_pc = '0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  issue_ra = '0;
  logic [4:0]  issue_rb = '0;
  logic [31:0] issue_a = '0;
  logic [31:0] issue_b = '0;
  logic        flush = 1'b0;
  logic        div_op_valid;
  logic [31:0] div_op_code;
  logic [31:0] div_op_pc;
  logic        div_op_invalid;
  logic [4:0]  div_op_rd;
  logic [4:0]  div_op_ra;
  logic [4:0]  div_op_rb;
  logic [31:0] div_op_a;
  logic [31:0] div_op_b;
  logic        div_res_valid;
  logic [31:0] div_res_out;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [31:0] wb_pc;
  logic [4:0]  chk_ra = '0;
  logic [4:0]  chk_rb = '0;
  logic        hazard;
  logic        busy;
  logic        err_timeout;

  logic        stub_silent = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          op_pulses = 0;
  int          wb_count = 0;
  logic [68:0] exp_q[$];

  riscv_div_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_pc(issue_pc),
    .issue_rd(issue_rd), .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_a(issue_a), .issue_b(issue_b), .flush(flush),
    .div_op_valid(div_op_valid), .div_op_code(div_op_code),
    .div_op_pc(div_op_pc), .div_op_invalid(div_op_invalid),
    .div_op_rd(div_op_rd), .div_op_ra(div_op_ra), .div_op_rb(div_op_rb),
    .div_op_a(div_op_a), .div_op_b(div_op_b),
    .div_res_valid(div_res_valid), .div_res_out(div_res_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_value(wb_value), .wb_pc(wb_pc),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] div_model(input logic [31:0] code,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (code[14:12])
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  int dcnt;
  always @(posedge clk) begin
    div_res_valid <= 1'b0;
    if (rst_n) begin
      dcnt        <= 0;
      div_res_out <= '0;
    end else if (div_op_valid) begin
      dcnt <= LAT;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !stub_silent) begin
        div_res_valid <= 1'b1;
        div_res_out   <= div_model(div_op_code, div_op_a, div_op_b);
      end
    end
  end

  always @(negedge clk) begin
    logic [68:0] e;
    if (!rst_n && div_op_valid) op_pulses++;
    if (!rst_n && wb_valid && wb_ready && !flush) begin
      wb_count++;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e[68:64]));
        check("wb_value", wb_value, e[63:32]);
        check("wb_pc", wb_pc, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] match, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    issue_valid  = 1'b1;
    issue_opcode = match | (32'(rd) << 7) | (32'd1 << 15) | (32'd2 << 20);
    issue_rd     = rd;
    issue_ra     = 5'd1;
    issue_rb     = 5'd2;
    issue_a      = a;
    issue_b      = b;
    issue_pc     = pc;
    for (int i = 0; i < 200; i++) begin
      look();
      if (issue_ready && !flush) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    issue_valid = 1'b0;
    check("issue_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      look();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, w0, n;
    bit seen, bad;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    look();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_op_valid", 32'(div_op_valid), 32'd0);
    check("rst_op_rd", 32'(div_op_rd), 32'd0);
    check("rst_wb_value", wb_value, 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_invalid", 32'(div_op_invalid), 32'd0);
    tick();

    // 1: DIV -7/2 rd=5
    wb_ready = 1'b1;
    p0 = op_pulses;
    exp_q.push_back({5'd5, 32'hFFFF_FFFD, 32'h100});
    issue(INST_DIV, 5'd5, 32'hFFFF_FFF9, 32'd2, 32'h100);
    look();
    check("t1_op_valid", 32'(div_op_valid), 32'd1);
    check("t1_op_rd", 32'(div_op_rd), 32'd5);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    look();
    check("t1_op_pulse_once", 32'(div_op_valid), 32'd0);
    tick();
    wait_idle("t1_done");
    check("t1_pulses", 32'(op_pulses - p0), 32'd1);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: REMU 100%7 rd=3 with stalled grant
    wb_ready = 1'b0;
    exp_q.push_back({5'd3, 32'd2, 32'h200});
    issue(INST_REMU, 5'd3, 32'd100, 32'd7, 32'h200);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      look();
      if (wb_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tick();
    check("t2_wb_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      look();
      check("t2_stall_valid", 32'(wb_valid), 32'd1);
      check("t2_stall_value", wb_value, 32'd2);
      tick();
    end
    look();
    check("t2_stall_rd", 32'(wb_rd), 32'd3);
    tick();
    wb_ready = 1'b1;
    wait_idle("t2_done");
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3: DIV rd=8 flushed in flight
    w0 = wb_count;
    p0 = op_pulses;
    chk_ra = 5'd8;
    issue(INST_DIV, 5'd8, 32'd50, 32'd5, 32'h300);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    look();
    check("t3_kill_busy", 32'(busy), 32'd1);
    check("t3_kill_ready", 32'(issue_ready), 32'd0);
    check("t3_kill_hazard", 32'(hazard), 32'd0);
    tick();
    bad = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      look();
      if (!busy) break;
      if (issue_ready) bad = 1'b1;
      if (wb_valid) seen = 1'b1;
      tick();
    end
    tick();
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_ready_low", 32'(bad), 32'd0);
    check("t3_no_wb", 32'(seen || wb_count != w0), 32'd0);
    check("t3_pulses", 32'(op_pulses - p0), 32'd1);
    chk_ra = 5'd0;

    // 4: DIVU 5/0 rd=0
    w0 = wb_count;
    issue(INST_DIVU, 5'd0, 32'd5, 32'd0, 32'h400);
    look();
    check("t4_busy", 32'(busy), 32'd1);
    tick();
    seen = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      look();
      if (!busy) break;
      if (wb_valid) seen = 1'b1;
      if (hazard) bad = 1'b1;
      tick();
    end
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_no_wb", 32'(seen || wb_count != w0), 32'd0);
    check("t4_no_hazard", 32'(bad), 32'd0);

    // 5: hazard on pending rd=9, then back-to-back accept in WB
    wb_ready = 1'b0;
    chk_ra = 5'd9;
    exp_q.push_back({5'd9, 32'hFFFF_FFFF, 32'h500});
    issue(INST_REM, 5'd9, 32'hFFFF_FFF9, 32'd2, 32'h500);
    look();
    check("t5_haz_busy", 32'(hazard), 32'd1);
    tick();
    chk_ra = 5'd0;
    look();
    check("t5_haz_clear", 32'(hazard), 32'd0);
    tick();
    chk_ra = 5'd9;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      look();
      if (wb_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("t5_wb_seen", 32'(seen), 32'd1);
    check("t5_haz_wb", 32'(hazard), 32'd1);
    tick();
    chk_ra = 5'd0;
    chk_rb = 5'd9;
    look();
    check("t5_haz_rb", 32'(hazard), 32'd1);
    tick();
    chk_rb = 5'd0;
    look();
    check("t5_haz_none", 32'(hazard), 32'd0);
    tick();
    wb_ready = 1'b1;
    exp_q.push_back({5'd4, 32'd6, 32'h504});
    issue(INST_DIVU, 5'd4, 32'd20, 32'd3, 32'h504);
    look();
    check("t5_b2b_busy", 32'(busy), 32'd1);
    check("t5_b2b_wb_low", 32'(wb_valid), 32'd0);
    check("t5_b2b_op", 32'(div_op_valid), 32'd1);
    tick();
    wait_idle("t5_done");
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // 6: silent divider -> watchdog
    stub_silent = 1'b1;
    w0 = wb_count;
    issue(INST_DIV, 5'd7, 32'd9, 32'd3, 32'h600);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      look();
      if (!busy) break;
      n++;
      tick();
    end
    check("t6_busy_cycles", 32'(n), 32'd49);
    check("t6_err", 32'(err_timeout), 32'd1);
    check("t6_no_wb", 32'(wb_count - w0), 32'd0);
    tick();
    stub_silent = 1'b0;
    exp_q.push_back({5'd2, 32'd3, 32'h700});
    issue(INST_DIVU, 5'd2, 32'd9, 32'd3, 32'h700);
    wait_idle("t6_after_done");
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    check("t6_err_sticky", 32'(err_timeout), 32'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    look();
    check("t6_err_reset", 32'(err_timeout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
